// File: rtl/sdram_bram_responder.sv
// +----------------------------------------------------------------------+
// | sdram_bram_responder : block-RAM SDRAM slave with tagged read return |
// |                        and emulated refresh stalls                   |
// | Revision 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module sdram_bram_responder #(
  parameter int ADDR_BITS        = 14,
  parameter int BURST_LEN        = 8,
  parameter int READ_LATENCY     = 2,
  parameter int REFRESH_INTERVAL = 512,
  parameter int REFRESH_CYCLES   = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sdram_request,
  input  logic        sdram_write,
  input  logic [3:0]  sdram_master,
  input  logic [25:0] sdram_address,
  input  logic [31:0] sdram_wdata,
  input  logic [3:0]  sdram_byte_en,
  input  logic        sdram_burst,
  output logic        sdram_ready,
  output logic [31:0] sdram_rdata,
  output logic [3:0]  sdram_valid,
  output logic [3:0]  sdram_complete
);

  localparam int C_DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] C_MASK = ADDR_BITS'(BURST_LEN - 1);
  localparam int C_BC_W  = $clog2(BURST_LEN + 1);
  localparam int C_LAT_W = $clog2(READ_LATENCY + 1);
  localparam int C_REF_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam int C_RC_W  = $clog2(REFRESH_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_REFRESH = 2'd2
  } state_t;

  state_t               r_state;
  logic [31:0]          r_mem [C_DEPTH];
  logic [31:0]          r_ram_q;
  logic [ADDR_BITS-1:0] r_addr;
  logic [3:0]           r_tag;
  logic [C_BC_W-1:0]    r_issue_left;
  logic [C_LAT_W-1:0]   r_wait;
  logic                 r_beat_valid;
  logic                 r_beat_last;
  logic                 r_wr_done;
  logic [3:0]           r_wr_tag;
  logic [C_REF_W-1:0]   r_ref_count;
  logic                 r_pending;
  logic [C_RC_W-1:0]    r_ref_left;

  logic [ADDR_BITS-1:0] w_in_addr;
  logic [ADDR_BITS-1:0] w_rd_addr;
  logic                 w_last_beat;
  logic                 w_ready;
  logic                 w_accept;
  logic                 w_issue;
  logic                 w_wrap;
  logic                 w_ref_done;
  logic [C_BC_W-1:0]    w_beats;
  logic                 w_out_valid;
  logic                 w_unused_addr;

  // Next word in critical-word-first order, wrapping inside the burst block.
  function automatic logic [ADDR_BITS-1:0] f_wrap_next(input logic [ADDR_BITS-1:0] a);
    return (a & ~C_MASK) | ((a + 1'b1) & C_MASK);
  endfunction

  assign w_in_addr     = sdram_address[ADDR_BITS+1:2];
  assign w_unused_addr = ^{sdram_address[25:ADDR_BITS+2], sdram_address[1:0]};
  assign w_last_beat   = (r_state == ST_READ) && r_beat_valid && r_beat_last;
  assign w_ready       = !reset && !r_pending && ((r_state == ST_IDLE) || w_last_beat);
  assign w_accept      = w_ready && sdram_request;
  assign w_issue       = (r_state == ST_READ) && (r_wait == '0) && (r_issue_left != '0);
  assign w_rd_addr     = w_ready ? w_in_addr : r_addr;
  assign w_beats       = sdram_burst ? C_BC_W'(BURST_LEN) : C_BC_W'(1);
  assign w_wrap        = (REFRESH_INTERVAL != 0) &&
                         (r_ref_count == C_REF_W'(REFRESH_INTERVAL - 1));
  assign w_ref_done    = ((r_state == ST_REFRESH) && (r_ref_left == '0)) ||
                         ((r_state == ST_IDLE) && r_pending && (REFRESH_CYCLES == 1));

  // The RAM port reads every cycle; a beat is flagged valid one cycle after its issue.
  always_ff @(posedge clock) begin
    if (w_accept && sdram_write) begin
      for (int i = 0; i < 4; i++) begin
        if (sdram_byte_en[i]) r_mem[w_in_addr][8*i +: 8] <= sdram_wdata[8*i +: 8];
      end
    end
    r_ram_q <= r_mem[w_rd_addr];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_tag        <= 4'd0;
      r_issue_left <= '0;
      r_wait       <= '0;
      r_beat_valid <= 1'b0;
      r_beat_last  <= 1'b0;
      r_wr_done    <= 1'b0;
      r_wr_tag     <= 4'd0;
      r_ref_count  <= '0;
      r_pending    <= 1'b0;
      r_ref_left   <= '0;
    end else begin
      r_beat_valid <= 1'b0;
      r_beat_last  <= 1'b0;
      r_wr_done    <= 1'b0;

      if (w_wrap) r_ref_count <= '0;
      else        r_ref_count <= r_ref_count + 1'b1;
      r_pending <= (r_pending && !w_ref_done) || w_wrap;

      case (r_state)
        ST_IDLE: begin
          // The pending cycle itself counts toward the stall window.
          if (r_pending && (REFRESH_CYCLES > 1)) begin
            r_state    <= ST_REFRESH;
            r_ref_left <= C_RC_W'(REFRESH_CYCLES - 2);
          end
        end
        ST_READ: begin
          if (w_issue) begin
            r_beat_valid <= 1'b1;
            r_beat_last  <= (r_issue_left == C_BC_W'(1));
            r_addr       <= f_wrap_next(r_addr);
            r_issue_left <= r_issue_left - 1'b1;
          end else if (r_wait != '0) begin
            r_wait <= r_wait - 1'b1;
          end
          if (w_last_beat) begin
            if (r_pending) begin
              r_state    <= ST_REFRESH;
              r_ref_left <= C_RC_W'(REFRESH_CYCLES - 1);
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_REFRESH: begin
          if (r_ref_left == '0) r_state <= ST_IDLE;
          else                  r_ref_left <= r_ref_left - 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_accept) begin
        if (sdram_write) begin
          r_wr_done <= 1'b1;
          r_wr_tag  <= sdram_master;
          r_state   <= ST_IDLE;
        end else begin
          r_state <= ST_READ;
          r_tag   <= sdram_master;
          if (READ_LATENCY == 1) begin
            r_beat_valid <= 1'b1;
            r_beat_last  <= (w_beats == C_BC_W'(1));
            r_addr       <= f_wrap_next(w_in_addr);
            r_issue_left <= w_beats - 1'b1;
            r_wait       <= '0;
          end else begin
            r_addr       <= w_in_addr;
            r_issue_left <= w_beats;
            r_wait       <= C_LAT_W'(READ_LATENCY - 2);
          end
        end
      end
    end
  end

  assign w_out_valid    = !reset && r_beat_valid;
  assign sdram_ready    = w_ready;
  assign sdram_valid    = w_out_valid ? r_tag : 4'd0;
  assign sdram_rdata    = w_out_valid ? r_ram_q : 32'd0;
  assign sdram_complete = reset ? 4'd0 :
                          (r_beat_valid && r_beat_last) ? r_tag :
                          r_wr_done ? r_wr_tag : 4'd0;

endmodule

`default_nettype wire

// File: doc/sdram_bram_responder.md
Name: sdram_bram_responder

Overview:
- Slave end of the arbiter-to-SDRAM interface, built on block RAM with tagged read return and emulated refresh stalls.
- Accepts the registered request bundle (request, write, master tag, address, wdata, byte_en, burst) and drives ready, rdata, valid tag and complete tag.
- Used as the memory behind the arbiter in simulation and on small FPGA builds with no external SDRAM.
- Also serves as a timing-accurate stand-in so arbiter and cache handshakes can be verified.

Parameters:
- ADDR_BITS, 14, word-address bits implemented (depth 2^ADDR_BITS x 32); upper address bits ignored (aliasing).
- BURST_LEN, 8, words returned per burst read (power of 2).
- READ_LATENCY, 2, cycles from accept edge to first valid beat (min 1).
- REFRESH_INTERVAL, 512, cycles between refresh stalls; 0 disables refresh.
- REFRESH_CYCLES, 6, cycles ready is held low per refresh (min 1).

Ports:
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- sdram_request  in  1  request valid
- sdram_write  in  1  1=write, 0=read
- sdram_master  in  4  master tag (1..5; 0 = none)
- sdram_address  in  26  byte address; word = address[ADDR_BITS+1:2]
- sdram_wdata  in  32  write data
- sdram_byte_en  in  4  byte lane enables, bit i -> wdata[8i+7:8i]
- sdram_burst  in  1  read burst of BURST_LEN words; ignored on writes
- sdram_ready  out  1  slave can accept a request this cycle
- sdram_rdata  out  32  read data; 0 when valid==0
- sdram_valid  out  4  tag of master owning rdata this cycle; 0 = none
- sdram_complete  out  4  tag of master whose transaction finishes this cycle; 0 = none

Behaviour:
- Accept = rising edge with sdram_request && sdram_ready. Inputs are sampled only at accept.
- States: IDLE, READ, REFRESH.
- Ready rules:
  - ready = (state==IDLE && !refresh_pending) || (state==READ && last beat driven this cycle && !refresh_pending).
  - ready is combinational from registered state only; it never depends on request.
- Reset:
  - During reset: ready=0, valid=0, complete=0, rdata=0, refresh counter=0, state=IDLE.
  - First cycle after reset: ready=1.
  - Reset mid-read aborts the transaction; no further valid/complete for it. RAM contents are preserved.
- Write (IDLE, accept):
  - Only the enabled byte lanes of word[address] are written at the accept edge.
  - The following cycle: complete=tag, valid=0.
  - State stays IDLE and ready stays high, so back-to-back writes run at 1 per cycle.
  - byte_en=0 writes nothing but still completes.
- Read (IDLE, accept):
  - Go to READ with a latched tag, word address and beat count (1 if !burst, else BURST_LEN).
  - Beat k (k=0..n-1) is on cycle accept+READ_LATENCY+k: valid=tag, rdata=word[base + ((start+k) mod BURST_LEN)].
  - base is the BURST_LEN-aligned block; start is the low word bits. Beats are critical-word-first, wrap within the block, and are consecutive with no gaps.
  - On the last beat, complete=tag. The next state is IDLE, or REFRESH if refresh is pending.
  - Ready is low from the accept edge until the last-beat cycle.
- Read-after-write: the read returns the newly written data, with no hazard.
- Refresh:
  - A free-running counter wraps at REFRESH_INTERVAL-1 and sets refresh_pending.
  - When pending and in IDLE (or at the last read beat), enter REFRESH for REFRESH_CYCLES with ready=0, then clear pending and return to IDLE.
  - A request arriving while pending or in REFRESH is held off, not dropped.
  - The counter keeps running during stalls.
  - If pending sets in the same cycle as a request, ready is already low, so the request is not accepted.
- valid and complete never carry tag 0. Write-complete and read-beat outputs never overlap: a read cannot be accepted before the write-complete cycle, and READ_LATENCY is at least 1.

Test Plan:
- Write tag 1, addr 0x40, wdata 0xDEADBEEF, byte_en 4'hF; then single read tag 1, addr 0x40 -> complete=1 one cycle after write; valid=1, rdata=0xDEADBEEF, complete=1 at accept+2; ready low only during the read.
- Write 0x11223344 to 0x80, then write 0xAABBCCDD with byte_en 4'b0101 to 0x80; read back -> rdata=0x11BB33DD.
- Preload words 0..7 = 0x100+i; burst read tag 2, addr 0x14 (word 5) -> 8 consecutive beats with valid=2, data 0x105,0x106,0x107,0x100,...,0x104; complete=2 with the last beat; ready rises on the last beat.
- REFRESH_INTERVAL=16, REFRESH_CYCLES=6, request held high continuously -> ready low for 6 cycles every 16; the request is accepted once ready returns; no lost or duplicated transaction.
- Assert reset during beat 3 of a burst -> valid/complete 0 from the next cycle; ready=1 on the first cycle after reset; prior RAM contents intact on a subsequent read.
- Back-to-back writes tags 1,3,1 on consecutive cycles, then a read tag 5 -> complete sequence 1,3,1 on consecutive cycles; read data is correct with valid=5.
